// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared pipeline constants for the MEM/WB, write-back and forwarding logic
package pipeline_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  // Bit positions inside the 2-bit WB control flag
  localparam int WB_FLAG_MEMTOREG = 1;
  localparam int WB_FLAG_REGWRITE = 0;

  localparam int REG_ZERO = 0;

endpackage

// File: rtl/wb_writeback_mux.sv
// rtl/wb_writeback_mux.sv - MemtoReg select between load data and ALU result
module wb_writeback_mux
  import pipeline_pkg::*;
#(
  parameter int DW = DATA_W
) (
  input  logic          mem_to_reg,
  input  logic [DW-1:0] read_data_mem,
  input  logic [DW-1:0] alu_result,
  output logic [DW-1:0] write_data
);

  always_comb begin
    write_data = mem_to_reg ? read_data_mem : alu_result;
  end

endmodule

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - write-back stage and 2-read/1-write register file with write-through bypass
module wb_regfile
  import pipeline_pkg::*;
#(
  parameter int DATA_W = pipeline_pkg::DATA_W,
  parameter int ADDR_W = pipeline_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        WB_Flag,
  input  logic [DATA_W-1:0] WB_ReadDataMem,
  input  logic [DATA_W-1:0] WB_ALUResult,
  input  logic [ADDR_W-1:0] WB_WriteReg,
  input  logic [ADDR_W-1:0] ID_ReadReg1,
  input  logic [ADDR_W-1:0] ID_ReadReg2,
  output logic [DATA_W-1:0] ID_ReadData1,
  output logic [DATA_W-1:0] ID_ReadData2,
  output logic [DATA_W-1:0] WB_WriteData
);

  localparam int NREGS = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic              wr_en;

  wb_writeback_mux #(.DW(DATA_W)) u_wb_mux (
    .mem_to_reg    (WB_Flag[WB_FLAG_MEMTOREG]),
    .read_data_mem (WB_ReadDataMem),
    .alu_result    (WB_ALUResult),
    .write_data    (WB_WriteData)
  );

  // Same qualifier gates both the commit and the bypass so they can never disagree
  always_comb begin
    wr_en = WB_Flag[WB_FLAG_REGWRITE] && !rst && (WB_WriteReg != ZERO_IDX);
  end

  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      regs_d[WB_WriteReg] = WB_WriteData;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NREGS; i++) begin
      regs_q[i] <= rst ? '0 : regs_d[i];
    end
  end

  always_comb begin
    ID_ReadData1 = '0;
    if (!rst && ID_ReadReg1 != ZERO_IDX) begin
      ID_ReadData1 = (wr_en && WB_WriteReg == ID_ReadReg1) ? WB_WriteData : regs_q[ID_ReadReg1];
    end
  end

  always_comb begin
    ID_ReadData2 = '0;
    if (!rst && ID_ReadReg2 != ZERO_IDX) begin
      ID_ReadData2 = (wr_en && WB_WriteReg == ID_ReadReg2) ? WB_WriteData : regs_q[ID_ReadReg2];
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - scoreboard bench for wb_regfile against an array reference model
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  WB_Flag = 2'b00;
  logic [31:0] WB_ReadDataMem = '0;
  logic [31:0] WB_ALUResult = '0;
  logic [4:0]  WB_WriteReg = '0;
  logic [4:0]  ID_ReadReg1 = '0;
  logic [4:0]  ID_ReadReg2 = '0;
  logic [31:0] ID_ReadData1;
  logic [31:0] ID_ReadData2;
  logic [31:0] WB_WriteData;

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk            (clk),
    .rst            (rst),
    .WB_Flag        (WB_Flag),
    .WB_ReadDataMem (WB_ReadDataMem),
    .WB_ALUResult   (WB_ALUResult),
    .WB_WriteReg    (WB_WriteReg),
    .ID_ReadReg1    (ID_ReadReg1),
    .ID_ReadReg2    (ID_ReadReg2),
    .ID_ReadData1   (ID_ReadData1),
    .ID_ReadData2   (ID_ReadData2),
    .WB_WriteData   (WB_WriteData)
  );

  typedef struct {
    string       name;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] wd;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] model [32];
  int          checks = 0;
  int          errors = 0;
  bit          stim_done = 1'b0;

  function automatic logic [31:0] model_read(input logic r, input logic [1:0] f,
                                             input logic [31:0] wd, input logic [4:0] wr,
                                             input logic [4:0] idx);
    if (r || idx == 5'd0) return 32'd0;
    if (f[0] && wr == idx) return wd;
    return model[idx];
  endfunction

  // Drive one cycle of inputs, push the expected response, then advance the model past the next edge
  task automatic drive(input string nm, input logic r, input logic [1:0] f,
                       input logic [31:0] mem, input logic [31:0] alu,
                       input logic [4:0] wr, input logic [4:0] r1, input logic [4:0] r2);
    exp_t        e;
    logic [31:0] wd;
    @(posedge clk);
    #1;
    rst = r; WB_Flag = f; WB_ReadDataMem = mem; WB_ALUResult = alu;
    WB_WriteReg = wr; ID_ReadReg1 = r1; ID_ReadReg2 = r2;
    wd = f[1] ? mem : alu;
    e.name = nm;
    e.wd   = wd;
    e.rd1  = model_read(r, f, wd, wr, r1);
    e.rd2  = model_read(r, f, wd, wr, r2);
    sb_q.push_back(e);
    if (r) begin
      for (int i = 0; i < 32; i++) model[i] = 32'd0;
    end else if (f[0] && wr != 5'd0) begin
      model[wr] = wd;
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checks += 3;
        if (ID_ReadData1 !== e.rd1) begin
          errors++;
          $display("FAIL %s rd1: got %h expected %h", e.name, ID_ReadData1, e.rd1);
        end
        if (ID_ReadData2 !== e.rd2) begin
          errors++;
          $display("FAIL %s rd2: got %h expected %h", e.name, ID_ReadData2, e.rd2);
        end
        if (WB_WriteData !== e.wd) begin
          errors++;
          $display("FAIL %s wd: got %h expected %h", e.name, WB_WriteData, e.wd);
        end
      end
    end
  end

  initial begin : stimulus
    logic [1:0]  f;
    logic [4:0]  wr, r1, r2;
    logic        r;
    for (int i = 0; i < 32; i++) model[i] = 32'd0;

    drive("reset_hold",   1'b1, 2'b01, 32'h0, 32'h55, 5'd5, 5'd5, 5'd0);
    drive("load_r5",      1'b0, 2'b01, 32'h0, 32'h1234, 5'd5, 5'd5, 5'd1);
    drive("r5_visible",   1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 5'd5, 5'd5);
    drive("rst_wr_lost",  1'b1, 2'b01, 32'h0, 32'h9999, 5'd5, 5'd5, 5'd5);
    drive("r5_after_rst", 1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 5'd5, 5'd5);
    drive("alu_wb",       1'b0, 2'b01, 32'h0, 32'hDEADBEEF, 5'd8, 5'd1, 5'd2);
    drive("alu_wb_read",  1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 5'd8, 5'd0);
    drive("load_wb",      1'b0, 2'b11, 32'h0000CAFE, 32'h11111111, 5'd9, 5'd8, 5'd7);
    drive("load_wb_read", 1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 5'd9, 5'd8);
    drive("bypass_same",  1'b0, 2'b01, 32'h0, 32'hA5A5A5A5, 5'd3, 5'd3, 5'd3);
    drive("bypass_b2b",   1'b0, 2'b01, 32'h0, 32'h5A5A5A5A, 5'd3, 5'd3, 5'd3);
    drive("b2b_read",     1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 5'd3, 5'd9);
    drive("zero_write",   1'b0, 2'b01, 32'h0, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd0);
    drive("zero_next",    1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 5'd0, 5'd3);
    drive("set_r4",       1'b0, 2'b01, 32'h0, 32'h77, 5'd4, 5'd0, 5'd0);
    drive("no_regwrite",  1'b0, 2'b10, 32'h0BADF00D, 32'h22, 5'd4, 5'd4, 5'd4);
    drive("r4_kept",      1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 5'd4, 5'd3);

    for (int n = 0; n < 400; n++) begin
      r  = ($urandom_range(0, 49) == 0);
      f  = 2'($urandom_range(0, 3));
      wr = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      r1 = ($urandom_range(0, 2) == 0) ? wr : 5'($urandom_range(0, 7));
      r2 = ($urandom_range(0, 3) == 0) ? r1 : 5'($urandom_range(0, 31));
      drive("random", r, f, $urandom, $urandom, wr, r1, r2);
    end

    for (int t = 0; t < 20 && sb_q.size() > 0; t++) @(posedge clk);
    @(posedge clk);
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
